// File: rtl/led_pattern_player_pkg.sv
// Shared types and constants for the LED pattern player.
// Holds the FSM state enum, geometry constants and the period clamp rule.
package led_pkg;

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   localparam int unsigned STEPS              = 8;
   localparam int unsigned IDX_W              = 3;
   localparam int unsigned PER_W              = 32;
   localparam int unsigned MIN_PERIOD_DEFAULT = 1000;

   // 0 means stop; any nonzero period shorter than the minimum is raised to it.
   function automatic logic [PER_W-1:0] eff_period(input logic [PER_W-1:0] p,
                                                   input logic [PER_W-1:0] min_p);
      logic [PER_W-1:0] r;
      if (p == '0) begin
         r = '0;
      end else if (p < min_p) begin
         r = min_p;
      end else begin
         r = p;
      end
      return r;
   endfunction

endpackage

// File: rtl/led_pattern_player_if.sv
// Command/status bundle between the UART command decoder and the LED player.
// master = decoder side, slave = player side.
interface led_pattern_player_if;

   logic [led_pkg::STEPS-1:0] ctrl;
   logic [led_pkg::PER_W-1:0] time_ctrl;
   logic                      cfg_valid;
   logic                      led;
   logic [led_pkg::IDX_W-1:0] step_idx;
   logic                      busy;
   logic                      cfg_ack;

   modport master (
      output ctrl, time_ctrl, cfg_valid,
      input  led, step_idx, busy, cfg_ack
   );

   modport slave (
      input  ctrl, time_ctrl, cfg_valid,
      output led, step_idx, busy, cfg_ack
   );

endinterface

// File: rtl/led_pattern_player_step_timer.sv
// Step timer: holds the active period and the in-step cycle counter.
// tick_o marks the last cycle of a step; a zero period halts counting.
module step_timer
   import led_pkg::*;
(
   input  logic             sclk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [PER_W-1:0] per_i,
   output logic             tick_o
);

   logic [PER_W-1:0] per_q, per_d;
   logic [PER_W-1:0] cnt_q, cnt_d;

   // per_q is either 0 or >= the clamp minimum, so per_q-1 cannot underflow when used.
   always_comb begin
      tick_o = (per_q != '0) && (cnt_q == (per_q - PER_W'(1)));
      per_d  = per_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         per_d = per_i;
         cnt_d = '0;
      end else if (tick_o) begin
         cnt_d = '0;
      end else if (per_q != '0) begin
         cnt_d = cnt_q + PER_W'(1);
      end
   end

   always_ff @(posedge sclk_i) begin
      if (!rst_ni) begin
         per_q <= '0;
         cnt_q <= '0;
      end else begin
         per_q <= per_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_pattern_player.sv
// LED blink pattern player: double-buffered commands applied on step boundaries.
// FSM, pending buffer and LED mux live here; step timing is in step_timer.
module led_pattern_player
   import led_pkg::*;
#(
   parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
   input logic                 sclk,
   input logic                 rst,
   led_pattern_player_if.slave cmd
);

   state_e           state_q, state_d;
   logic [STEPS-1:0] pat_q, pat_d;
   logic [IDX_W-1:0] step_q, step_d;
   logic             led_q, led_d;
   logic             ack_q, ack_d;
   logic [STEPS-1:0] pend_pat_q, pend_pat_d;
   logic [PER_W-1:0] pend_per_q, pend_per_d;
   logic             pend_v_q, pend_v_d;

   logic             tick;
   logic             load;
   logic [PER_W-1:0] load_per;
   logic [PER_W-1:0] in_per;
   logic             apply;
   logic [STEPS-1:0] apply_pat;
   logic [PER_W-1:0] apply_per;

   assign in_per = eff_period(cmd.time_ctrl, PER_W'(MIN_PERIOD));

   step_timer u_timer (
      .sclk_i (sclk),
      .rst_ni (rst),
      .load_i (load),
      .per_i  (load_per),
      .tick_o (tick)
   );

   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      step_d     = step_q;
      led_d      = led_q;
      ack_d      = 1'b0;
      pend_pat_d = pend_pat_q;
      pend_per_d = pend_per_q;
      pend_v_d   = pend_v_q;
      load       = 1'b0;
      load_per   = '0;
      apply      = 1'b0;
      apply_pat  = cmd.ctrl;
      apply_per  = in_per;

      case (state_q)
         IDLE: begin
            if (cmd.cfg_valid) apply = 1'b1;
         end
         RUN: begin
            if (tick) begin
               // A strobe on the boundary beats the pending command and discards it.
               if (cmd.cfg_valid) begin
                  apply = 1'b1;
               end else if (pend_v_q) begin
                  apply     = 1'b1;
                  apply_pat = pend_pat_q;
                  apply_per = pend_per_q;
               end else begin
                  step_d = step_q + IDX_W'(1);
                  led_d  = pat_q[step_d];
               end
               pend_v_d = 1'b0;
            end else if (cmd.cfg_valid) begin
               pend_pat_d = cmd.ctrl;
               pend_per_d = in_per;
               pend_v_d   = 1'b1;
            end
         end
      endcase

      if (apply) begin
         ack_d    = 1'b1;
         step_d   = '0;
         load     = 1'b1;
         load_per = apply_per;
         if (apply_per == '0) begin
            state_d = IDLE;
            led_d   = 1'b0;
         end else begin
            state_d = RUN;
            pat_d   = apply_pat;
            led_d   = apply_pat[0];
         end
      end
   end

   always_ff @(posedge sclk) begin
      if (!rst) begin
         state_q    <= IDLE;
         pat_q      <= '0;
         step_q     <= '0;
         led_q      <= 1'b0;
         ack_q      <= 1'b0;
         pend_pat_q <= '0;
         pend_per_q <= '0;
         pend_v_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pat_q      <= pat_d;
         step_q     <= step_d;
         led_q      <= led_d;
         ack_q      <= ack_d;
         pend_pat_q <= pend_pat_d;
         pend_per_q <= pend_per_d;
         pend_v_q   <= pend_v_d;
      end
   end

   assign cmd.led      = led_q;
   assign cmd.step_idx = step_q;
   assign cmd.busy     = (state_q == RUN);
   assign cmd.cfg_ack  = ack_q;

endmodule

// File: tb/tb_led_pattern_player.sv
// Testbench for led_pattern_player: vector table plus hand-written corner sequences,
// with expected per-cycle outputs queued on a scoreboard and popped after each edge.
module tb_led_pattern_player;

   logic sclk = 1'b0;
   logic rst  = 1'b0;

   always #5 sclk = ~sclk;

   led_pattern_player_if bus ();

   led_pattern_player #(.MIN_PERIOD(4)) dut (
      .sclk (sclk),
      .rst  (rst),
      .cmd  (bus.slave)
   );

   typedef struct {
      logic       led;
      logic [2:0] step;
      logic       busy;
      logic       ack;
   } obs_t;

   typedef struct {
      logic [7:0]  ctrl;
      logic [31:0] tc;
      logic [7:0]  seq;
      int unsigned per;
   } vec_t;

   obs_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic obs_t run_exp(input logic [7:0] seq, input int unsigned per,
                                    input int unsigned j);
      obs_t        e;
      int unsigned st;
      st     = (j / per) % 8;
      e.led  = seq[st[2:0]];
      e.step = st[2:0];
      e.busy = 1'b1;
      e.ack  = (j == 0);
      return e;
   endfunction

   function automatic obs_t idle_exp(input logic ack);
      obs_t e;
      e.led  = 1'b0;
      e.step = 3'd0;
      e.busy = 1'b0;
      e.ack  = ack;
      return e;
   endfunction

   // One clock: queue the expectation, advance past the edge, then compare.
   task automatic cyc(input obs_t e, input string tag);
      obs_t x;
      sb.push_back(e);
      @(posedge sclk);
      #1;
      bus.cfg_valid = 1'b0;
      x = sb.pop_front();
      check({tag, ".led"},      {31'd0, bus.led},      {31'd0, x.led});
      check({tag, ".step_idx"}, {29'd0, bus.step_idx}, {29'd0, x.step});
      check({tag, ".busy"},     {31'd0, bus.busy},     {31'd0, x.busy});
      check({tag, ".cfg_ack"},  {31'd0, bus.cfg_ack},  {31'd0, x.ack});
   endtask

   task automatic strobe(input logic [7:0] c, input logic [31:0] t);
      bus.ctrl      = c;
      bus.time_ctrl = t;
      bus.cfg_valid = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cyc(idle_exp(1'b0), "reset");
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[6];
      vt[0] = '{ctrl: 8'hA5, tc: 32'd4, seq: 8'b1010_0101, per: 4};
      vt[1] = '{ctrl: 8'h3C, tc: 32'd1, seq: 8'b0011_1100, per: 4};
      vt[2] = '{ctrl: 8'hFF, tc: 32'd5, seq: 8'b1111_1111, per: 5};
      vt[3] = '{ctrl: 8'h00, tc: 32'd4, seq: 8'b0000_0000, per: 4};
      vt[4] = '{ctrl: 8'h96, tc: 32'd6, seq: 8'b1001_0110, per: 6};
      vt[5] = '{ctrl: 8'h5A, tc: 32'd0, seq: 8'b0000_0000, per: 0};

      bus.ctrl      = '0;
      bus.time_ctrl = '0;
      bus.cfg_valid = 1'b0;

      for (int r = 0; r < 6; r++) begin
         do_reset();
         strobe(vt[r].ctrl, vt[r].tc);
         if (vt[r].per == 0) begin
            cyc(idle_exp(1'b1), $sformatf("vec%0d", r));
            for (int k = 0; k < 6; k++) cyc(idle_exp(1'b0), $sformatf("vec%0d", r));
         end else begin
            for (int unsigned k = 0; k < 8 * vt[r].per + 3; k++)
               cyc(run_exp(vt[r].seq, vt[r].per, k), $sformatf("vec%0d", r));
         end
      end

      // Pending: two commands during one step, only the latest is applied at the boundary.
      do_reset();
      strobe(8'h0F, 32'd10);
      for (int unsigned k = 0; k < 10 + 6 * 8 + 2; k++) begin
         if (k == 4) strobe(8'hF0, 32'd4);
         if (k == 7) strobe(8'h3C, 32'd6);
         if (k < 10) cyc(run_exp(8'b0000_1111, 10, k), "pend");
         else        cyc(run_exp(8'b0011_1100, 6, k - 10), "pend");
      end

      // Collision: strobe on the boundary cycle wins over the pending command.
      do_reset();
      strobe(8'h0F, 32'd4);
      for (int unsigned k = 0; k < 4 + 5 * 8 + 2; k++) begin
         if (k == 2) strobe(8'hF0, 32'd4);
         if (k == 4) strobe(8'h3C, 32'd5);
         if (k < 4) cyc(run_exp(8'b0000_1111, 4, k), "collide");
         else       cyc(run_exp(8'b0011_1100, 5, k - 4), "collide");
      end

      // Stop: zero period queued while running returns to IDLE at the boundary.
      do_reset();
      strobe(8'hA5, 32'd4);
      for (int unsigned k = 0; k < 10; k++) begin
         if (k == 2) strobe(8'hFF, 32'd0);
         if (k < 4)       cyc(run_exp(8'b1010_0101, 4, k), "stop");
         else if (k == 4) cyc(idle_exp(1'b1), "stop");
         else             cyc(idle_exp(1'b0), "stop");
      end

      // Reset mid-step with a pending command: everything clears, nothing resumes.
      do_reset();
      strobe(8'hA5, 32'd4);
      for (int unsigned k = 0; k < 16; k++) begin
         if (k == 2) strobe(8'h3C, 32'd4);
         if (k == 3) rst = 1'b0;
         if (k == 4) rst = 1'b1;
         if (k < 3) cyc(run_exp(8'b1010_0101, 4, k), "rstmid");
         else       cyc(idle_exp(1'b0), "rstmid");
      end
      strobe(8'h81, 32'd4);
      for (int unsigned k = 0; k < 10; k++)
         cyc(run_exp(8'b1000_0001, 4, k), "restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_pattern_player.md
# led_pattern_player

Downstream stage of the UART command decoder: takes the decoded `ctrl` byte and `time_ctrl` step period and drives the board LED with an 8-step blink pattern. New commands are double-buffered and take effect at the next step boundary, so the pattern never glitches. All outputs are registered.

## Interface
- `STEPS`, 8, pattern length in steps; bit `i` of `ctrl` is the LED level in step `i`.
- `MIN_PERIOD`, 1000, minimum step length in `sclk` cycles; shorter nonzero periods are raised to this value.
- `sclk`  in  1  system clock; the block has one clock domain.
- `rst`  in  1  synchronous, active-low reset.
- `ctrl`  in  8  pattern bits, sampled only when `cfg_valid` is high.
- `time_ctrl`  in  32  step period in cycles, sampled only when `cfg_valid` is high; 0 means stop.
- `cfg_valid`  in  1  one-cycle strobe from the decoder marking a new command.
- `led`  out  1  LED drive; 1 means on.
- `step_idx`  out  3  current step, 0..7.
- `busy`  out  1  high while in RUN.
- `cfg_ack`  out  1  one-cycle pulse on the cycle a command becomes active.

## Operation
- The FSM has two states, IDLE and RUN.
- Active registers: `pat[7:0]`, `per[31:0]`, `cnt[31:0]`.
- Pending registers: `pend_pat`, `pend_per`, `pend_v`.
- Effective period: 0 stays 0 (stop); 1..MIN_PERIOD-1 becomes MIN_PERIOD; anything else passes unchanged.
- IDLE, `cfg_valid` with nonzero effective period:
  - load active registers directly; `cnt`←0, `step_idx`←0, `led`←`ctrl[0]`, `cfg_ack`←1;
  - go to RUN.
- IDLE, `cfg_valid` with period 0: `cfg_ack`←1; stay in IDLE; `led` stays 0.
- RUN, each cycle:
  - if `cnt == per-1` (the boundary): `cnt`←0 and `step_idx`←`step_idx+1` mod 8, wrapping 7→0;
  - otherwise `cnt`←`cnt+1`.
  - `led` = `pat[step_idx]` for the new `step_idx`.
- RUN, `cfg_valid` away from the boundary:
  - store into the pending registers and set `pend_v`;
  - a later `cfg_valid` before the boundary overwrites them (latest wins).
- RUN, boundary with `pend_v` set:
  - apply the pending command: `step_idx`←0, `cnt`←0, `led`←`pend_pat[0]`, `cfg_ack`←1, `pend_v`←0;
  - if the pending period is 0: go to IDLE with `led`←0, `step_idx`←0.
- RUN, `cfg_valid` on the boundary cycle itself: the incoming command takes priority over `pend_v` and is applied on that same edge, using the same rules as above.
- `ctrl = 8'hFF` gives a steady-on LED and `ctrl = 8'h00` a steady-off LED; both still run in RUN, and `busy` stays 1.
- `rst` low at any time (including mid-step or with a pending command): on the next edge all registers clear, the FSM goes to IDLE and `pend_v`←0.
- Reset values: `led`=0, `step_idx`=0, `busy`=0, `cfg_ack`=0.

## Timing
- IDLE→RUN latency is 1 cycle: with `cfg_valid` at edge T, `led`, `busy` and `cfg_ack` are valid after edge T.
- Each step lasts exactly `per` cycles; the full pattern repeats every 8·`per` cycles.
- Pending-command latency is the cycles left to the boundary, at most `per`.
- `cfg_ack` is high for exactly one cycle per applied command; a command overwritten while pending produces no ack.
- `cfg_valid` has no backpressure; the block is never not-ready.
- Counter arithmetic is unsigned 32-bit. `per-1` is evaluated only when `per ≥ MIN_PERIOD`, so it never underflows.

## Structure
- Shared package `led_pkg` holds:
  - the state enum {IDLE, RUN};
  - `STEPS`, the default `MIN_PERIOD`, and the period width (32).
- One sub-module, `step_timer`, is natural: it holds `per` and `cnt`, takes a load/clear input, and outputs a `tick` on the boundary.
- The FSM, pending buffer and LED mux stay in the top module.

## Test plan
- Reset, then `cfg_valid` with `ctrl`=8'hA5, `time_ctrl`=4 (bench MIN_PERIOD=4) → `led` sequence 1,0,1,0,0,1,0,1, each level held 4 cycles; `cfg_ack` pulses once, 1 cycle after the strobe.
- Clamp: `time_ctrl`=1 with MIN_PERIOD=4 → steps last 4 cycles.
- Pending: running 8'h0F/per 10, then at `cnt`=3 send 8'hF0/per 4 and at `cnt`=6 send 8'h3C/per 6 → only 8'h3C is applied, at the boundary; `step_idx`=0, one `cfg_ack`.
- Boundary collision: `cfg_valid` on the exact boundary cycle while a pending command exists → the strobed command wins and is applied that edge.
- Stop: `time_ctrl`=0 while running → at the next boundary go to IDLE with `led`=0, `busy`=0, `cfg_ack`=1.
- `rst` low mid-step with a pending command → next edge all outputs 0, state IDLE; after release the LED stays off until a new `cfg_valid`.
